// File: rtl/test_encode_pkg.sv
// Package shared by the encoder generator and the downstream encoder checker.
// Holds the scan FSM state encoding, the default w-axis modulus and a small
// helper that maps a programmed period onto the period actually used.
package test_encode_pkg;

  // Scan FSM states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLead = 2'd1,
    StRun  = 2'd2,
    StTail = 2'd3
  } state_e;

  // Default w-axis wrap modulus; w spans 0..W_MOD_DEFAULT-1.
  localparam logic [31:0] W_MOD_DEFAULT = 32'h0003_FFFF;

  // A period of 0 behaves as 1 (one sample every cycle).
  function automatic logic [15:0] eff_period(input logic [15:0] period);
    return (period == 16'd0) ? 16'd1 : period;
  endfunction

endpackage

// File: rtl/test_encode_wrap_add.sv
// Combinational modular add for the w axis.
// Ports:
//   w_i      : current w (< W_MOD)
//   step_i   : increment (< W_MOD)
//   w_next_o : (w_i + step_i) mod W_MOD
//   wrap_o   : high when the sum reached or passed W_MOD
module test_encode_wrap_add
  import test_encode_pkg::*;
#(
  parameter logic [31:0] W_MOD = W_MOD_DEFAULT
) (
  input  logic [31:0] w_i,
  input  logic [31:0] step_i,
  output logic [31:0] w_next_o,
  output logic        wrap_o
);

  logic [32:0] w_sum;
  logic [31:0] w_red;

  // 33-bit sum so the wrap decision never overflows.
  assign w_sum = {1'b0, w_i} + {1'b0, step_i};
  // Only the low 32 bits of the reduced value are needed; modular 32-bit
  // subtraction yields them exactly.
  assign w_red = w_sum[31:0] - W_MOD;

  assign wrap_o   = (w_sum >= {1'b0, W_MOD});
  assign w_next_o = wrap_o ? w_red : w_sum[31:0];

endmodule

// File: rtl/test_encode_gen.sv
// Encoder test-pattern generator.
// Emits a stream of (x, w) encoder samples: w advances by a fixed step modulo
// W_MOD on every strobe, and x (revolution count) increments on each wrap.
// A scan runs IDLE -> LEAD (period cycles) -> RUN (strobes every period
// cycles) -> TAIL (period cycles) -> IDLE, pulsing done_o on the way out.
//
// Optional feature: define TEST_ENCODE_GEN_ERR_INJ_EN to add inj_i /
// inj_delta_i / err_inj_cnt_o. Each inj_i pulse seen in RUN makes the next
// strobe use step + inj_delta_i (mod W_MOD); inj_delta_i must be < W_MOD.
//
// Ports:
//   clk_i, rst_n_i       : clock, asynchronous active-low reset
//   start_i, stop_i      : single-cycle scan start / stop pulses
//   period_i             : cycles between samples (0 treated as 1)
//   step_i               : w increment per sample (< W_MOD)
//   num_samples_i        : sample limit (0 = unlimited)
//   w_init_i             : first w (>= W_MOD replaced by 0)
//   scan_en_o            : high in LEAD and RUN
//   encode_en_o          : sample strobe
//   encode_x_o           : revolution count
//   encode_w_o           : w position
//   sample_cnt_o         : samples emitted in the current scan
//   done_o               : one-cycle pulse at scan completion
module test_encode_gen
  import test_encode_pkg::*;
#(
  parameter real         TCQ   = 0.1,
  parameter logic [31:0] W_MOD = W_MOD_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic [15:0] period_i,
  input  logic [31:0] step_i,
  input  logic [31:0] num_samples_i,
  input  logic [31:0] w_init_i,
`ifdef TEST_ENCODE_GEN_ERR_INJ_EN
  input  logic        inj_i,
  input  logic [31:0] inj_delta_i,
  output logic [7:0]  err_inj_cnt_o,
`endif
  output logic        scan_en_o,
  output logic        encode_en_o,
  output logic [31:0] encode_x_o,
  output logic [31:0] encode_w_o,
  output logic [31:0] sample_cnt_o,
  output logic        done_o
);

  // TCQ only models register delay in simulation; reject nonsense values.
  if (TCQ < 0.0 || W_MOD == 32'd0) begin : g_param_chk
    $error("test_encode_gen: TCQ must be >= 0 and W_MOD must be nonzero");
  end

  state_e      r_state;
  logic [15:0] r_per_cnt;
  logic [15:0] r_period;
  logic [31:0] r_step;
  logic [31:0] r_limit;
  logic [31:0] r_w_init;
  logic        r_first;
  logic        r_scan_en;
  logic        r_en;
  logic [31:0] r_x;
  logic [31:0] r_w;
  logic [31:0] r_sample_cnt;
  logic        r_done;

  logic        w_per_hit;
  logic        w_limit_hit;
  logic [31:0] w_stp_w;
  logic        w_stp_wrap;
  logic [31:0] w_add_w;
  logic        w_add_wrap;
  logic [31:0] w_next_w;
  logic        w_next_wrap;

  test_encode_wrap_add #(
    .W_MOD(W_MOD)
  ) u_add_step (
    .w_i     (r_w),
    .step_i  (r_step),
    .w_next_o(w_stp_w),
    .wrap_o  (w_stp_wrap)
  );

`ifdef TEST_ENCODE_GEN_ERR_INJ_EN
  logic        r_inj_pend;
  logic [31:0] r_inj_delta;
  logic [7:0]  r_inj_cnt;
  logic [31:0] w_inj_add;
  logic        w_inj_wrap;

  // Second stage adds the injected delta on top of the normal step.
  test_encode_wrap_add #(
    .W_MOD(W_MOD)
  ) u_add_inj (
    .w_i     (w_stp_w),
    .step_i  (r_inj_pend ? r_inj_delta : 32'd0),
    .w_next_o(w_inj_add),
    .wrap_o  (w_inj_wrap)
  );

  assign w_add_w       = w_inj_add;
  assign w_add_wrap    = w_stp_wrap | w_inj_wrap;
  assign err_inj_cnt_o = r_inj_cnt;
`else
  assign w_add_w    = w_stp_w;
  assign w_add_wrap = w_stp_wrap;
`endif

  always_comb begin
    w_per_hit   = (r_per_cnt == r_period);
    w_limit_hit = (r_limit != 32'd0) && (r_sample_cnt == r_limit);
    // The first strobe of a scan carries w_init unmodified.
    w_next_w    = r_first ? r_w_init : w_add_w;
    w_next_wrap = !r_first && w_add_wrap;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= StIdle;
      r_per_cnt    <= 16'd0;
      r_period     <= 16'd0;
      r_step       <= 32'd0;
      r_limit      <= 32'd0;
      r_w_init     <= 32'd0;
      r_first      <= 1'b0;
      r_scan_en    <= 1'b0;
      r_en         <= 1'b0;
      r_x          <= 32'd0;
      r_w          <= 32'd0;
      r_sample_cnt <= 32'd0;
      r_done       <= 1'b0;
`ifdef TEST_ENCODE_GEN_ERR_INJ_EN
      r_inj_pend   <= 1'b0;
      r_inj_delta  <= 32'd0;
      r_inj_cnt    <= 8'd0;
`endif
    end else begin
      r_en   <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start_i) begin
            r_state      <= StLead;
            r_scan_en    <= 1'b1;
            r_per_cnt    <= 16'd1;
            r_period     <= eff_period(period_i);
            r_step       <= step_i;
            r_limit      <= num_samples_i;
            r_w_init     <= (w_init_i >= W_MOD) ? 32'd0 : w_init_i;
            r_first      <= 1'b1;
            r_x          <= 32'd0;
            r_sample_cnt <= 32'd0;
`ifdef TEST_ENCODE_GEN_ERR_INJ_EN
            r_inj_pend   <= 1'b0;
`endif
          end
        end
        StLead: begin
          if (stop_i) begin
            r_state   <= StTail;
            r_scan_en <= 1'b0;
            r_per_cnt <= 16'd1;
          end else if (w_per_hit) begin
            r_state   <= StRun;
            r_per_cnt <= 16'd1;
          end else begin
            r_per_cnt <= r_per_cnt + 16'd1;
          end
        end
        StRun: begin
          if (w_limit_hit) begin
            // Limit reached on the previous strobe: no further strobes.
            r_state   <= StTail;
            r_scan_en <= 1'b0;
            r_per_cnt <= 16'd1;
          end else begin
            if (w_per_hit) begin
              r_en         <= 1'b1;
              r_w          <= w_next_w;
              r_x          <= r_x + {31'd0, w_next_wrap};
              r_sample_cnt <= r_sample_cnt + 32'd1;
              r_first      <= 1'b0;
              r_per_cnt    <= 16'd1;
            end else begin
              r_per_cnt <= r_per_cnt + 16'd1;
            end
            // A stop coinciding with a strobe lets that strobe complete.
            if (stop_i) begin
              r_state   <= StTail;
              r_scan_en <= 1'b0;
              r_per_cnt <= 16'd1;
            end
          end
`ifdef TEST_ENCODE_GEN_ERR_INJ_EN
          if (w_per_hit && !w_limit_hit && !r_first) begin
            r_inj_pend <= 1'b0;
          end
          // A fresh pulse wins over consumption in the same cycle.
          if (inj_i) begin
            r_inj_pend  <= 1'b1;
            r_inj_delta <= inj_delta_i;
            if (r_inj_cnt != 8'hFF) begin
              r_inj_cnt <= r_inj_cnt + 8'd1;
            end
          end
`endif
        end
        StTail: begin
          if (w_per_hit) begin
            r_state   <= StIdle;
            r_done    <= 1'b1;
            r_per_cnt <= 16'd0;
          end else begin
            r_per_cnt <= r_per_cnt + 16'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign scan_en_o    = r_scan_en;
  assign encode_en_o  = r_en;
  assign encode_x_o   = r_x;
  assign encode_w_o   = r_w;
  assign sample_cnt_o = r_sample_cnt;
  assign done_o       = r_done;

endmodule

// File: tb/tb_test_encode_gen.sv
// Directed testbench for test_encode_gen. Expected values are hand-computed
// for W_MOD = 0x3FFFF. Define TEST_ENCODE_GEN_ERR_INJ_EN to also exercise
// the error-injection ports.
module tb_test_encode_gen;

  localparam logic [31:0] WM = 32'h0003_FFFF;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [15:0] period;
  logic [31:0] step;
  logic [31:0] num;
  logic [31:0] winit;
  logic        scan_en;
  logic        enc_en;
  logic [31:0] enc_x;
  logic [31:0] enc_w;
  logic [31:0] scnt;
  logic        done;
`ifdef TEST_ENCODE_GEN_ERR_INJ_EN
  logic        inj;
  logic [31:0] inj_delta;
  logic [7:0]  inj_cnt;
`endif

  test_encode_gen #(
    .W_MOD(WM)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .stop_i       (stop),
    .period_i     (period),
    .step_i       (step),
    .num_samples_i(num),
    .w_init_i     (winit),
`ifdef TEST_ENCODE_GEN_ERR_INJ_EN
    .inj_i        (inj),
    .inj_delta_i  (inj_delta),
    .err_inj_cnt_o(inj_cnt),
`endif
    .scan_en_o    (scan_en),
    .encode_en_o  (enc_en),
    .encode_x_o   (enc_x),
    .encode_w_o   (enc_w),
    .sample_cnt_o (scnt),
    .done_o       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total;
  int          bad;
  int          n_st;
  int          done_cyc;
  int          drop_cyc;
  int          st_cyc [16];
  logic [31:0] st_w   [16];
  logic [31:0] st_x   [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Downstream wrapped-difference checker.
  function automatic logic [31:0] wdiff(input logic [31:0] cur, input logic [31:0] prev);
    return (cur >= prev) ? cur - prev : cur + WM - prev;
  endfunction

  // Starts a scan and records strobes until done_o or the cycle budget runs
  // out. Cycle 0 is the edge that accepts start_i. stop_n >= 0 pulses stop_i
  // once that many strobes have been seen; inj_n likewise pulses inj_i.
  task automatic run_scan(input logic [15:0] p, input logic [31:0] s, input logic [31:0] n,
                          input logic [31:0] wi, input int stop_n, input int inj_n,
                          input int budget);
    bit stopped;
    period   = p;
    step     = s;
    num      = n;
    winit    = wi;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    chk("scan_en_after_start", {31'd0, scan_en}, 32'd1);
    n_st     = 0;
    done_cyc = -1;
    drop_cyc = -1;
    stopped  = 1'b0;
    if (stop_n == 0) begin
      stop    = 1'b1;
      stopped = 1'b1;
    end
    for (int c = 1; c <= budget; c++) begin
      tick();
      stop = 1'b0;
`ifdef TEST_ENCODE_GEN_ERR_INJ_EN
      inj = 1'b0;
`endif
      if (enc_en) begin
        if (n_st < 16) begin
          st_cyc[n_st] = c;
          st_w[n_st]   = enc_w;
          st_x[n_st]   = enc_x;
        end
        n_st++;
        if (!stopped && n_st == stop_n) begin
          stop    = 1'b1;
          stopped = 1'b1;
        end
`ifdef TEST_ENCODE_GEN_ERR_INJ_EN
        if (n_st == inj_n) begin
          inj       = 1'b1;
          inj_delta = 32'd50;
        end
`endif
      end
      if (!scan_en && drop_cyc < 0) drop_cyc = c;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    chk("done_seen_in_budget", {31'd0, (done_cyc > 0)}, 32'd1);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    period = 16'd0;
    step   = 32'd0;
    num    = 32'd0;
    winit  = 32'd0;
`ifdef TEST_ENCODE_GEN_ERR_INJ_EN
    inj       = 1'b0;
    inj_delta = 32'd0;
`endif

    // Reset state.
    #12;
    chk("rst_scan_en", {31'd0, scan_en}, 32'd0);
    chk("rst_encode_en", {31'd0, enc_en}, 32'd0);
    chk("rst_x", enc_x, 32'd0);
    chk("rst_w", enc_w, 32'd0);
    chk("rst_cnt", scnt, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic run: period 4, step 100, 5 samples.
    run_scan(16'd4, 32'd100, 32'd5, 32'd0, -1, -1, 60);
    chk("basic_nst", n_st, 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("basic_w%0d", i), st_w[i], 32'(i * 100));
      chk($sformatf("basic_cyc%0d", i), st_cyc[i], 32'(8 + 4 * i));
    end
    chk("basic_cnt", scnt, 32'd5);
    chk("basic_drop", drop_cyc, 32'd25);
    chk("basic_done", done_cyc, 32'd29);
    tick();
    chk("basic_done_width", {31'd0, done}, 32'd0);
    chk("basic_w_hold", enc_w, 32'd400);

    // Wrap: w 0x3FFF0 -> 0x11 -> 0x31, x 0 -> 1.
    run_scan(16'd2, 32'h20, 32'd3, 32'h3FFF0, -1, -1, 60);
    chk("wrap_nst", n_st, 3);
    chk("wrap_w0", st_w[0], 32'h3FFF0);
    chk("wrap_w1", st_w[1], 32'h11);
    chk("wrap_w2", st_w[2], 32'h31);
    chk("wrap_x0", st_x[0], 32'd0);
    chk("wrap_x1", st_x[1], 32'd1);
    chk("wrap_x2", st_x[2], 32'd1);
    chk("wrap_diff1", wdiff(st_w[1], st_w[0]), 32'h20);
    chk("wrap_diff2", wdiff(st_w[2], st_w[1]), 32'h20);
    chk("wrap_x_hold", enc_x, 32'd1);

    // Unlimited scan stopped after the third strobe.
    run_scan(16'd3, 32'd7, 32'd0, 32'd5, 3, -1, 60);
    chk("stop_nst", n_st, 3);
    chk("stop_cnt", scnt, 32'd3);
    chk("stop_cyc0", st_cyc[0], 32'd6);
    chk("stop_x_cleared", st_x[0], 32'd0);
    chk("stop_w2", st_w[2], 32'd19);
    chk("stop_drop", drop_cyc, 32'd13);
    chk("stop_done", done_cyc, 32'd16);

    // Period 0 acts as 1; out-of-range w_init becomes 0.
    run_scan(16'd0, 32'd1, 32'd4, WM + 32'd5, -1, -1, 40);
    chk("p0_nst", n_st, 4);
    chk("p0_w0", st_w[0], 32'd0);
    chk("p0_w3", st_w[3], 32'd3);
    chk("p0_cyc0", st_cyc[0], 32'd2);
    chk("p0_cyc3", st_cyc[3], 32'd5);
    chk("p0_done", done_cyc, 32'd7);

    // Stop during LEAD: zero samples, TAIL of 5 cycles.
    run_scan(16'd5, 32'd1, 32'd0, 32'd0, 0, -1, 40);
    chk("lead_stop_nst", n_st, 0);
    chk("lead_stop_cnt", scnt, 32'd0);
    chk("lead_stop_drop", drop_cyc, 32'd1);
    chk("lead_stop_done", done_cyc, 32'd6);

`ifdef TEST_ENCODE_GEN_ERR_INJ_EN
    // One injected sample of diff 150, then back to 100.
    run_scan(16'd2, 32'd100, 32'd5, 32'd0, -1, 1, 60);
    chk("inj_nst", n_st, 5);
    chk("inj_diff1", wdiff(st_w[1], st_w[0]), 32'd150);
    chk("inj_diff2", wdiff(st_w[2], st_w[1]), 32'd100);
    chk("inj_diff4", wdiff(st_w[4], st_w[3]), 32'd100);
    chk("inj_cnt", {24'd0, inj_cnt}, 32'd1);
`endif

    // Asynchronous reset mid-RUN.
    period = 16'd2;
    step   = 32'd3;
    num    = 32'd0;
    winit  = 32'd9;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (8) tick();
    chk("arst_pre_scan_en", {31'd0, scan_en}, 32'd1);
    chk("arst_pre_w", enc_w, 32'd15);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_scan_en", {31'd0, scan_en}, 32'd0);
    chk("arst_encode_en", {31'd0, enc_en}, 32'd0);
    chk("arst_x", enc_x, 32'd0);
    chk("arst_w", enc_w, 32'd0);
    chk("arst_cnt", scnt, 32'd0);
    repeat (3) begin
      tick();
      chk("arst_no_done", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (4) begin
      tick();
      chk("arst_idle_after", {31'd0, scan_en | done | enc_en}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
